// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle: two writeback requesters in, one register-file
// write port and the clear-in-progress flag out.
interface rf_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              RegWrite;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              busy;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  RegWrite, waddr, wdata, busy
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output RegWrite, waddr, wdata, busy
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks onto one register-file write port.
// Define RF_CLEAR_ON_RESET_EN to zero registers 1..2**ADDR_W-1 after every reset.
module rf_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic              clk,
   input logic              rst,
   rf_write_arbiter_if.slave bus
);
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic              in_clear;
   logic [ADDR_W-1:0] clr_addr;

`ifdef RF_CLEAR_ON_RESET_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_CLEAR;
         clr_cnt_reg <= ADDR_ONE;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      if (state_reg == ST_CLEAR) begin
         clr_cnt_next = clr_cnt_reg + ADDR_ONE;
         if (&clr_cnt_reg) begin
            state_next = ST_RUN;
         end
      end
   end

   assign in_clear = (state_reg == ST_CLEAR);
   assign clr_addr = clr_cnt_reg;
`else
   assign in_clear = 1'b0;
   assign clr_addr = '0;
`endif

   // last_grant_reg = 1 means requester 1 won the most recent transfer
   logic              last_grant_reg, last_grant_next;
   logic              wr_en_reg, wr_en_next;
   logic [ADDR_W-1:0] waddr_reg, waddr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic              run_ok, grant1, ready0, ready1, accept, clearing;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   always_comb begin
      run_ok          = !rst && !in_clear;
      grant1          = bus.req1_valid && (!bus.req0_valid || !last_grant_reg);
      ready0          = run_ok && bus.req0_valid && !grant1;
      ready1          = run_ok && grant1;
      accept          = ready0 || ready1;
      sel_addr        = grant1 ? bus.req1_addr : bus.req0_addr;
      sel_data        = grant1 ? bus.req1_data : bus.req0_data;
      last_grant_next = accept ? grant1 : last_grant_reg;
      // x0 is hardwired: the transfer completes but nothing is written
      wr_en_next      = accept && (sel_addr != '0);
      waddr_next      = accept ? sel_addr : waddr_reg;
      wdata_next      = accept ? sel_data : wdata_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_reg <= 1'b1;
         wr_en_reg      <= 1'b0;
         waddr_reg      <= '0;
         wdata_reg      <= '0;
      end else begin
         last_grant_reg <= last_grant_next;
         wr_en_reg      <= wr_en_next;
         waddr_reg      <= waddr_next;
         wdata_reg      <= wdata_next;
      end
   end

   // Clear writes are driven straight from the counter so they line up with busy
   assign clearing       = in_clear && !rst;
   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.RegWrite   = clearing ? 1'b1 : wr_en_reg;
   assign bus.waddr      = clearing ? clr_addr : waddr_reg;
   assign bus.wdata      = clearing ? '0 : wdata_reg;
   assign bus.busy       = in_clear;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized scoreboard bench for rf_write_arbiter: requester queues drive the ports,
// expected register writes are queued and matched by an independent write monitor.
`timescale 1ns/1ps
module tb_rf_write_arbiter;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 1 << AW;
`ifdef RF_CLEAR_ON_RESET_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   clear_left = 0;
   bit   last_model = 1'b1;   // 1: requester 1 was granted last
   exp_t exp_q[$];
   req_t p0_q[$];
   req_t p1_q[$];

   rf_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) rf_bus ();

   rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (rf_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.addr = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NREG - 1));
      r.data = $urandom();
      return r;
   endfunction

   // One clock of stimulus plus the handshake/busy checks for that clock
   task automatic step(input bit rst_val);
      bit   v0, v1, g0, g1, exp_busy;
      req_t r;
      @(posedge clk);
      #1;
      if (rst_val) begin
         exp_q.delete();
         last_model = 1'b1;
      end
      if (!rst_val && rst) begin
         clear_left = CLR_EN ? NREG - 1 : 0;
         for (int k = 1; k <= clear_left; k++)
            exp_q.push_back('{cyc + k - 1, AW'(k), DW'(0)});
      end
      rst = rst_val;
      v0 = (p0_q.size() > 0);
      v1 = (p1_q.size() > 0);
      rf_bus.req0_valid = v0;
      rf_bus.req1_valid = v1;
      if (v0) begin
         rf_bus.req0_addr = p0_q[0].addr;
         rf_bus.req0_data = p0_q[0].data;
      end
      if (v1) begin
         rf_bus.req1_addr = p1_q[0].addr;
         rf_bus.req1_data = p1_q[0].data;
      end
      @(negedge clk);
      exp_busy = CLR_EN && (rst || clear_left > 0);
      g0 = 1'b0;
      g1 = 1'b0;
      if (!rst && !exp_busy) begin
         if (v0 && v1) begin
            g0 = last_model;
            g1 = !last_model;
         end else begin
            g0 = v0;
            g1 = v1;
         end
      end
      check("busy", 64'(rf_bus.busy), 64'(exp_busy));
      check("req0_ready", 64'(rf_bus.req0_ready), 64'(g0));
      check("req1_ready", 64'(rf_bus.req1_ready), 64'(g1));
      if (rst) begin
         check("rst_waddr", 64'(rf_bus.waddr), 64'(0));
         check("rst_wdata", 64'(rf_bus.wdata), 64'(0));
      end
      if (g0 || g1) begin
         r = g0 ? p0_q.pop_front() : p1_q.pop_front();
         $display("cyc=%0d accept port%0d x%0d <= %08h", cyc, g1, r.addr, r.data);
         if (r.addr != '0)
            exp_q.push_back('{cyc + 1, r.addr, r.data});
         last_model = g1;
      end
      if (!rst && clear_left > 0)
         clear_left--;
   endtask

   // Write monitor: every RegWrite must match the oldest expected write, on its cycle
   always @(negedge clk) begin
      exp_t e;
      if (rf_bus.RegWrite === 1'b1) begin
         $display("cyc=%0d write x%0d <= %08h", cyc, rf_bus.waddr, rf_bus.wdata);
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write cyc=%0d got x%0d <= %08h expected no write",
                     cyc, rf_bus.waddr, rf_bus.wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_cycle", 64'(cyc), 64'(e.due));
            check("waddr", 64'(rf_bus.waddr), 64'(e.addr));
            check("wdata", 64'(rf_bus.wdata), 64'(e.data));
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e = exp_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_write cyc=%0d got RegWrite=%b expected x%0d <= %08h",
                  cyc, rf_bus.RegWrite, e.addr, e.data);
      end
   end

   initial begin
      rf_bus.req0_valid = 1'b0;
      rf_bus.req0_addr  = '0;
      rf_bus.req0_data  = '0;
      rf_bus.req1_valid = 1'b0;
      rf_bus.req1_addr  = '0;
      rf_bus.req1_data  = '0;

      // Request pending through reset: must wait for the clear (or go first cycle without it)
      p0_q.push_back('{AW'(7), DW'(32'h0000_0777)});
      repeat (3) step(1'b1);
      repeat (10) step(1'b0);
      repeat (2) step(1'b1);
      repeat (40) step(1'b0);

      // Leave requester 1 as last grant so the tie below starts with requester 0
      p1_q.push_back('{AW'(2), DW'(32'h2222_2222)});
      repeat (3) step(1'b0);
      p0_q.push_back('{AW'(3), DW'(32'hA0A0_0001)});
      p0_q.push_back('{AW'(3), DW'(32'hA0A0_0002)});
      p1_q.push_back('{AW'(4), DW'(32'hB1B1_0001)});
      p1_q.push_back('{AW'(4), DW'(32'hB1B1_0002)});
      repeat (6) step(1'b0);
      p0_q.push_back('{AW'(5), DW'(32'hDEAD_BEEF)});
      repeat (3) step(1'b0);
      p1_q.push_back('{AW'(0), DW'(32'h0000_1234)});
      repeat (3) step(1'b0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1 && p0_q.size() < 3) p0_q.push_back(rand_req());
         if ($urandom_range(0, 1) == 1 && p1_q.size() < 3) p1_q.push_back(rand_req());
         step(i >= 300 && i < 302);
      end
      repeat (60) step(1'b0);

      check("pending_writes", 64'(exp_q.size()), 64'(0));
      check("port0_drained", 64'(p0_q.size()), 64'(0));
      check("port1_drained", 64'(p1_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; register count is 2**ADDR_W.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 req0_valid  in  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  in  ADDR_W  requester 0 destination register.
REQ-007 req0_data  in  DATA_W  requester 0 write data.
REQ-008 req0_ready  out  1  requester 0 write accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready: same as REQ-005..008, for requester 1 (load writeback).
REQ-010 RegWrite  out  1  register-file write enable.
REQ-011 waddr  out  ADDR_W  register-file write address.
REQ-012 wdata  out  DATA_W  register-file write data.
REQ-013 busy  out  1  clear sequence in progress; no requests accepted.

Function
REQ-014 The block SHALL have states CLEAR and RUN.
REQ-015 A transfer on port i SHALL occur when reqi_valid && reqi_ready at a rising clk edge.
REQ-016 In RUN, reqi_ready SHALL be combinational: high only for the single granted port, and only when that port's valid is high.
REQ-017 In CLEAR, both readies SHALL be 0.
REQ-018 Grant: if exactly one valid is high, that port SHALL be granted.
REQ-019 If both valids are high, the port not granted at the most recent transfer SHALL be granted (round-robin).
REQ-020 The last-grant pointer SHALL update only on a completed transfer.
REQ-021 On a transfer, the next cycle SHALL drive RegWrite=1, waddr=accepted addr and wdata=accepted data, all registered (latency 1 cycle).
REQ-022 RegWrite SHALL be 0 in any RUN cycle that follows a cycle with no transfer.
REQ-023 A transfer with addr 0 SHALL be accepted, but the next cycle SHALL drive RegWrite=0, because x0 is never written.
REQ-024 Back-to-back transfers SHALL be accepted every cycle with no bubble.
REQ-025 A requester SHALL hold valid, addr and data stable until it sees ready; the block does not check this.
REQ-026 Simultaneous writes to the same address from both ports SHALL be serialized in grant order, so the later grant's data is final.
REQ-027 In CLEAR, an internal counter SHALL step from 1 to 2**ADDR_W-1, one register per cycle, with RegWrite=1, waddr=counter and wdata=0.
REQ-028 After the cycle that writes register 2**ADDR_W-1, the state SHALL be RUN.
REQ-029 busy SHALL be 1 exactly while the state is CLEAR.

Reset
REQ-030 Asserting rst SHALL asynchronously force: RegWrite=0, waddr=0, wdata=0, last-grant pointer=1 (so req0 wins the first tie), clear counter=1.
REQ-031 Asserting rst SHALL set the state to CLEAR when the clear feature is compiled in, otherwise RUN.
REQ-032 While rst is high, req0_ready and req1_ready SHALL be 0.
REQ-033 Reset during CLEAR SHALL restart the clear from register 1.
REQ-034 A transfer already accepted but not yet written when rst asserts SHALL be discarded.

Configuration
REQ-035 Macro RF_CLEAR_ON_RESET_EN defined: the CLEAR state and counter SHALL be present; after rst deasserts, busy=1 for 2**ADDR_W-1 cycles (31 at default).
REQ-036 Macro RF_CLEAR_ON_RESET_EN undefined: the CLEAR state and counter SHALL be absent, busy SHALL be tied to 0, and the block SHALL accept requests in the first cycle after rst deasserts.

Verification
REQ-037 Macro defined, release rst -> RegWrite=1, wdata=0 with waddr 1,2,...,31 over 31 cycles, busy=1 throughout; then busy=0.
REQ-038 RUN, req0 only: addr=5, data=0xDEADBEEF -> req0_ready=1 that cycle; next cycle RegWrite=1, waddr=5, wdata=0xDEADBEEF.
REQ-039 RUN, both valid for 4 cycles (req0 addr 3, req1 addr 4) -> grants 0,1,0,1; waddr 3,4,3,4, one per cycle with no bubble.
REQ-040 Transfer with req1 addr=0, data=0x1234 -> req1_ready=1; next cycle RegWrite=0.
REQ-041 Assert rst at clear step 10, release -> clear restarts at waddr=1; no request accepted before clear ends.
REQ-042 Macro undefined, req0 valid addr=7 in the first cycle after rst release -> accepted; next cycle RegWrite=1, waddr=7; busy=0 at all times.
